sorter8: RTL and testbench

//  Fully pipelined 8-element sorting network for (first, second) tuple pairs.
//  It is a building block for the AoC day-5 range-merge datapath: 8 ranges go in
//  per cycle, and 8 ranges come out in sorted order a fixed 6 cycles later.

---
 rtl/sorter8.sv | 99 +++++++++
 tb/tb_sorter8.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sorter8.sv
// Fully pipelined 8-element bitonic sorter for {first, second} tuple pairs.
// Six compare-exchange layers, each followed by a register stage; latency 6, throughput 1/cycle.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

module sorter8 #(
  parameter bit asc        = 1'b1,
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        valid_in,
  input  logic [16*DATA_WIDTH-1:0]    pairs_in_flat,
  output logic                        valid_out,
  output logic [16*DATA_WIDTH-1:0]    pairs_out_flat
);

  localparam int PAIR_W = 2 * DATA_WIDTH;
  localparam int FLAT_W = 8 * PAIR_W;

  // layer_in[l] feeds compare-exchange layer l; layer_out[l] is its combinational result
  logic [PAIR_W-1:0] layer_in  [6][8];
  logic [PAIR_W-1:0] layer_out [6][8];

  logic [PAIR_W-1:0] stage_data_reg [5][8];
  logic [4:0]        stage_valid_reg;
  logic [PAIR_W-1:0] out_data_reg   [8];
  logic              valid_out_reg;

  genvar gi, gj;

  generate
    for (gi = 0; gi < 8; gi++) begin : g_io
      assign layer_in[0][gi]                  = pairs_in_flat[gi*PAIR_W +: PAIR_W];
      assign pairs_out_flat[gi*PAIR_W +: PAIR_W] = out_data_reg[gi];
    end

    for (gi = 1; gi < 6; gi++) begin : g_stage_taps
      for (gj = 0; gj < 8; gj++) begin : g_elem
        assign layer_in[gi][gj] = stage_data_reg[gi-1][gj];
      end
    end

    for (gi = 0; gi < 6; gi++) begin : g_layer
      localparam int DIST = (gi == 3) ? 4 : ((gi == 1 || gi == 4) ? 2 : 1);
      for (gj = 0; gj < 4; gj++) begin : g_cmp
        // Pair j at distance d: lower index = (j/d)*2d + j%d
        localparam int  IDX_A = (gj / DIST) * 2 * DIST + (gj % DIST);
        localparam int  IDX_B = IDX_A + DIST;
        // Ascending exchange only differs from descending inside the first two merge levels
        localparam bit  UP    = (gi == 0) ? ((IDX_A & 2) == 0) :
                                ((gi == 1 || gi == 2) ? ((IDX_A & 4) == 0) : 1'b1);
        localparam bit  MIN_TO_A = (UP == asc);

        logic a_lt_b;
        logic b_lt_a;
        logic swap;

        assign a_lt_b = layer_in[gi][IDX_A] < layer_in[gi][IDX_B];
        assign b_lt_a = layer_in[gi][IDX_B] < layer_in[gi][IDX_A];
        assign swap   = MIN_TO_A ? b_lt_a : a_lt_b;

        assign layer_out[gi][IDX_A] = swap ? layer_in[gi][IDX_B] : layer_in[gi][IDX_A];
        assign layer_out[gi][IDX_B] = swap ? layer_in[gi][IDX_A] : layer_in[gi][IDX_B];
      end
    end
  endgenerate

  // Data registers advance every cycle; only the valid bits qualify them
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage_valid_reg <= '0;
      valid_out_reg   <= 1'b0;
      for (int s = 0; s < 5; s++) begin
        for (int k = 0; k < 8; k++) begin
          stage_data_reg[s][k] <= '0;
        end
      end
      for (int k = 0; k < 8; k++) begin
        out_data_reg[k] <= '0;
      end
    end else begin
      stage_valid_reg <= {stage_valid_reg[3:0], valid_in};
      valid_out_reg   <= stage_valid_reg[4];
      for (int s = 0; s < 5; s++) begin
        for (int k = 0; k < 8; k++) begin
          stage_data_reg[s][k] <= layer_out[s][k];
        end
      end
      for (int k = 0; k < 8; k++) begin
        out_data_reg[k] <= layer_out[5][k];
      end
    end
  end

  assign valid_out = valid_out_reg;

endmodule

// File: tb/tb_sorter8.sv
// Bench for sorter8: ascending and descending instances share stimulus; a per-cycle
// input history plus a plain exchange sort predicts every output cycle.
module tb_sorter8;

  localparam int DW     = 64;
  localparam int PAIR_W = 2 * DW;
  localparam int FLAT_W = 8 * PAIR_W;
  localparam int LAT    = 5;   // steps between capture step and the step that sees the result
  localparam int HMAX   = 1024;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              valid_in = 1'b0;
  logic [FLAT_W-1:0] pairs_in_flat = '0;
  logic              valid_out_a, valid_out_d;
  logic [FLAT_W-1:0] pairs_out_a, pairs_out_d;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic              hist_valid [HMAX];
  logic [FLAT_W-1:0] hist_data  [HMAX];

  sorter8 #(.asc(1'b1), .DATA_WIDTH(DW)) u_asc (
    .clock(clock), .reset(reset), .valid_in(valid_in), .pairs_in_flat(pairs_in_flat),
    .valid_out(valid_out_a), .pairs_out_flat(pairs_out_a)
  );

  sorter8 #(.asc(1'b0), .DATA_WIDTH(DW)) u_desc (
    .clock(clock), .reset(reset), .valid_in(valid_in), .pairs_in_flat(pairs_in_flat),
    .valid_out(valid_out_d), .pairs_out_flat(pairs_out_d)
  );

  always #5 clock = ~clock;

  function automatic logic [PAIR_W-1:0] mk(input logic [DW-1:0] f, input logic [DW-1:0] s);
    return {f, s};
  endfunction

  function automatic logic [PAIR_W-1:0] elem(input logic [FLAT_W-1:0] x, input int i);
    return x[i*PAIR_W +: PAIR_W];
  endfunction

  function automatic logic [FLAT_W-1:0] sort_flat(input logic [FLAT_W-1:0] x, input bit up);
    logic [PAIR_W-1:0] e [8];
    logic [PAIR_W-1:0] t;
    logic [FLAT_W-1:0] r;
    for (int i = 0; i < 8; i++) e[i] = x[i*PAIR_W +: PAIR_W];
    for (int i = 0; i < 8; i++) begin
      for (int j = i + 1; j < 8; j++) begin
        if (up ? (e[j] < e[i]) : (e[j] > e[i])) begin
          t = e[i]; e[i] = e[j]; e[j] = t;
        end
      end
    end
    for (int i = 0; i < 8; i++) r[i*PAIR_W +: PAIR_W] = e[i];
    return r;
  endfunction

  function automatic logic [FLAT_W-1:0] rand_batch();
    logic [FLAT_W-1:0] r;
    int mode;
    logic [DW-1:0] f0, s0;
    mode = $urandom_range(0, 2);
    f0 = {$urandom, $urandom};
    s0 = {$urandom, $urandom};
    for (int i = 0; i < 8; i++) begin
      case (mode)
        0:       r[i*PAIR_W +: PAIR_W] = mk({$urandom, $urandom}, {$urandom, $urandom});
        1:       r[i*PAIR_W +: PAIR_W] = mk(DW'($urandom_range(0, 3)), DW'($urandom_range(0, 3)));
        default: r[i*PAIR_W +: PAIR_W] = mk(f0, s0);
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [PAIR_W-1:0] obs, input logic [PAIR_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [FLAT_W-1:0] d);
    valid_in      = v;
    pairs_in_flat = d;
  endtask

  // One clock: record what is being captured, then check both outputs against history
  task automatic step();
    logic exp_v;
    logic [FLAT_W-1:0] exp_a, exp_d;
    hist_valid[cyc] = valid_in;
    hist_data[cyc]  = pairs_in_flat;
    @(posedge clock);
    #1;
    exp_v = (cyc >= LAT) ? hist_valid[cyc-LAT] : 1'b0;
    chk("valid_asc", PAIR_W'(valid_out_a), PAIR_W'(exp_v));
    chk("valid_desc", PAIR_W'(valid_out_d), PAIR_W'(exp_v));
    if (exp_v) begin
      exp_a = sort_flat(hist_data[cyc-LAT], 1'b1);
      exp_d = sort_flat(hist_data[cyc-LAT], 1'b0);
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("data_asc[%0d]@%0d", i, cyc), elem(pairs_out_a, i), elem(exp_a, i));
        chk($sformatf("data_desc[%0d]@%0d", i, cyc), elem(pairs_out_d, i), elem(exp_d, i));
      end
    end
    cyc++;
  endtask

  logic [FLAT_W-1:0] b;
  logic [DW-1:0] firsts_in  [8] = '{5, 3, 9, 1, 7, 2, 8, 4};
  logic [DW-1:0] firsts_asc [8] = '{1, 2, 3, 4, 5, 7, 8, 9};
  logic [DW-1:0] firsts_dsc [8] = '{9, 8, 7, 5, 4, 3, 2, 1};
  logic [PAIR_W-1:0] tie_exp [8];

  initial begin
    for (int i = 0; i < HMAX; i++) begin
      hist_valid[i] = 1'b0;
      hist_data[i]  = '0;
    end

    // Power-on reset
    #12;
    for (int i = 0; i < 8; i++) begin
      chk("por_out_asc", elem(pairs_out_a, i), '0);
      chk("por_out_desc", elem(pairs_out_d, i), '0);
    end
    chk("por_valid", PAIR_W'(valid_out_a), '0);
    reset = 1'b0;

    // Single batch: explicit expected firsts for both directions
    for (int i = 0; i < 8; i++) b[i*PAIR_W +: PAIR_W] = mk(firsts_in[i], '0);
    drive(1'b1, b);
    step();
    drive(1'b0, '0);
    repeat (LAT) step();
    chk("single_valid", PAIR_W'(valid_out_a), PAIR_W'(1));
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("single_asc[%0d]", i), elem(pairs_out_a, i), mk(firsts_asc[i], '0));
      chk($sformatf("single_desc[%0d]", i), elem(pairs_out_d, i), mk(firsts_dsc[i], '0));
    end
    step();

    // Tie on first, ordered by second
    b = '0;
    b[0*PAIR_W +: PAIR_W] = mk(4, 9);
    b[1*PAIR_W +: PAIR_W] = mk(4, 1);
    b[2*PAIR_W +: PAIR_W] = mk(4, 5);
    for (int i = 0; i < 5; i++) tie_exp[i] = '0;
    tie_exp[5] = mk(4, 1);
    tie_exp[6] = mk(4, 5);
    tie_exp[7] = mk(4, 9);
    drive(1'b1, b);
    step();
    drive(1'b0, '0);
    repeat (LAT) step();
    for (int i = 0; i < 8; i++) chk($sformatf("tie_asc[%0d]", i), elem(pairs_out_a, i), tie_exp[i]);
    step();

    // Back-to-back: already sorted, reverse sorted, all equal
    for (int i = 0; i < 8; i++) b[i*PAIR_W +: PAIR_W] = mk(DW'(i), DW'(100 - i));
    drive(1'b1, b); step();
    for (int i = 0; i < 8; i++) b[i*PAIR_W +: PAIR_W] = mk(DW'(7 - i), DW'(i));
    drive(1'b1, b); step();
    for (int i = 0; i < 8; i++) b[i*PAIR_W +: PAIR_W] = mk(64'hdead_beef_0000_0001, 64'hffff_ffff_ffff_ffff);
    drive(1'b1, b); step();
    drive(1'b0, '0);
    repeat (LAT + 2) step();

    // Reset with a batch in flight: outputs clear at once, batch never appears
    drive(1'b1, rand_batch()); step();
    drive(1'b1, rand_batch()); step();
    drive(1'b0, rand_batch());
    repeat (3) step();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_valid_asc", PAIR_W'(valid_out_a), '0);
    chk("rst_valid_desc", PAIR_W'(valid_out_d), '0);
    for (int i = 0; i < 8; i++) begin
      chk("rst_out_asc", elem(pairs_out_a, i), '0);
      chk("rst_out_desc", elem(pairs_out_d, i), '0);
    end
    for (int i = 0; i < cyc; i++) hist_valid[i] = 1'b0;
    step();
    reset = 1'b0;
    drive(1'b0, '0);
    repeat (LAT + 2) step();

    // Random batches with random bubbles
    for (int n = 0; n < 200; n++) begin
      while ($urandom_range(0, 9) < 3) begin
        drive(1'b0, rand_batch());
        step();
      end
      drive(1'b1, rand_batch());
      step();
    end
    drive(1'b0, '0);
    repeat (LAT + 3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
